mult_sched: RTL and testbench

Round-robin scheduler that shares one shift-add multiplier engine between N requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one at a time, runs a fixed-latency W-cycle multiply, and returns the product tagged with the requester index on a single result port with backpressure. It sits between several arithmetic clients (filters, address generators) and the multiplier datapath, so the costly engine exists only once.

---
 rtl/mult_sched_pkg.sv | 26 ++
 rtl/mult_sched_if.sv | 32 +++
 rtl/mult_sched_rr_arb.sv | 65 ++++++
 rtl/mult_sched.sv | 172 +++++++++++++++++
 tb/tb_mult_sched.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types, width helpers and bench constants for the mult_sched block.
package mult_sched_pkg;

   // Controller state encoding; the top maps these onto localparam constants.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } fsm_e;

   // Width of an index into n items; a single item still gets one bit.
   function automatic int idw(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

   // Configuration used by the testbench.
   localparam int TB_W       = 8;
   localparam int TB_N       = 4;
   localparam int TB_LAT     = TB_W + 1;
   localparam int TB_TIMEOUT = 40;

endpackage

// File: rtl/mult_sched_if.sv
// Requester and result bundle of the shared multiplier scheduler.
interface mult_sched_if
   import mult_sched_pkg::*;
#(
   parameter int W = 8,
   parameter int N = 4
);
   localparam int IDW = idw(N);

   logic [N-1:0]          req_v;
   logic [N-1:0][W-1:0]   req_a;
   logic [N-1:0][W-1:0]   req_b;
   logic [N-1:0]          req_rdy;
   logic                  res_v;
   logic [2*W-1:0]        res_q;
   logic [IDW-1:0]        res_id;
   logic                  res_rdy;
   logic                  busy;

   // Clients and result consumer.
   modport master (
      output req_v, req_a, req_b, res_rdy,
      input  req_rdy, res_v, res_q, res_id, busy
   );

   // Scheduler side.
   modport slave (
      input  req_v, req_a, req_b, res_rdy,
      output req_rdy, res_v, res_q, res_id, busy
   );

endinterface

// File: rtl/mult_sched_rr_arb.sv
// Round-robin arbiter: first request at or above the pointer wins, with wrap.
// The pointer moves just past the winner whenever the grant is acknowledged.
module rr_arb
   import mult_sched_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = idw(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic           ack,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id
);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] next_ptr;
   logic           found;
   int             idx;

   // Search from the pointer upward, wrapping at N, and take the first request.
   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) begin
            idx = idx - N;
         end else begin
            idx = idx;
         end
         if (!found && req[IDW'(idx)]) begin
            gnt[IDW'(idx)] = 1'b1;
            gnt_id         = IDW'(idx);
            found          = 1'b1;
         end else begin
            found = found;
         end
      end
   end

   // Pointer value that follows the current winner, wrapping to zero.
   always_comb begin
      if (int'(gnt_id) >= N - 1) begin
         next_ptr = '0;
      end else begin
         next_ptr = gnt_id + IDW'(1);
      end
   end

   // Pointer register: cleared by reset, advanced only on an accepted grant.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr <= '0;
      end else if (ack) begin
         ptr <= next_ptr;
      end else begin
         ptr <= ptr;
      end
   end

endmodule

// File: rtl/mult_sched.sv
// Shares one shift-add multiplier between N requesters. A round-robin arbiter
// picks a requester in IDLE, the engine runs exactly W add/shift cycles, and
// the tagged product is held on the result port until the consumer takes it.
module mult_sched
   import mult_sched_pkg::*;
#(
   parameter int W = 8,
   parameter int N = 4
) (
   input  logic        clk,
   input  logic        rst,
   mult_sched_if.slave bus
);

   localparam int IDW = idw(N);
   localparam int CW  = idw(W);

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_CALC = CALC;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]     state;
   logic           idle;
   logic           accept;
   logic [N-1:0]   arb_req;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic [N-1:0]   rdy;

   logic [W-1:0]   a_reg;
   logic [2*W-1:0] b_reg;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] acc_next;
   logic [CW-1:0]  ctr;
   logic [IDW-1:0] id;

   logic           res_valid;
   logic [2*W-1:0] res_prod;
   logic [IDW-1:0] res_owner;
   logic           busy_reg;

   assign idle = (state == S_IDLE);

   // Requests only reach the arbiter while idle so the pointer cannot drift.
   always_comb begin
      if (idle) begin
         arb_req = bus.req_v;
      end else begin
         arb_req = '0;
      end
   end

   rr_arb #(
      .N   (N),
      .IDW (IDW)
   ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (arb_req),
      .ack    (accept),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   // Accept strobes: the arbiter grant while idle and out of reset; a single
   // requester is simply offered ready whenever the engine is idle.
   always_comb begin
      if (idle && rst) begin
         if (N == 1) begin
            rdy = {N{1'b1}};
         end else begin
            rdy = gnt;
         end
      end else begin
         rdy = '0;
      end
   end

   assign accept      = |(bus.req_v & rdy);
   assign bus.req_rdy = rdy;
   assign bus.res_v   = res_valid;
   assign bus.res_q   = res_prod;
   assign bus.res_id  = res_owner;
   assign bus.busy    = busy_reg;

   // Accumulator after this cycle's conditional add of the shifted multiplicand.
   always_comb begin
      if (a_reg[0]) begin
         acc_next = acc + b_reg;
      end else begin
         acc_next = acc;
      end
   end

   // Multiply engine: load operands on accept, then shift-add once per CALC cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         ctr   <= '0;
         id    <= '0;
      end else if (idle && accept) begin
         a_reg <= bus.req_a[gnt_id];
         b_reg <= {{W{1'b0}}, bus.req_b[gnt_id]};
         acc   <= '0;
         ctr   <= CW'(W - 1);
         id    <= gnt_id;
      end else if (state == S_CALC) begin
         a_reg <= a_reg >> 1;
         b_reg <= b_reg << 1;
         acc   <= acc_next;
         ctr   <= ctr - CW'(1);
         id    <= id;
      end else begin
         a_reg <= a_reg;
         b_reg <= b_reg;
         acc   <= acc;
         ctr   <= ctr;
         id    <= id;
      end
   end

   // Controller and registered result port; the result is captured on the last
   // CALC cycle and held unchanged for as long as the consumer stalls.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         res_valid <= 1'b0;
         res_prod  <= '0;
         res_owner <= '0;
         busy_reg  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state    <= S_CALC;
                  busy_reg <= 1'b1;
               end else begin
                  state    <= S_IDLE;
                  busy_reg <= 1'b0;
               end
            end
            S_CALC: begin
               if (ctr == '0) begin
                  state     <= S_DONE;
                  res_valid <= 1'b1;
                  res_prod  <= acc_next;
                  res_owner <= id;
               end else begin
                  state <= S_CALC;
               end
            end
            S_DONE: begin
               if (bus.res_rdy) begin
                  state     <= S_IDLE;
                  res_valid <= 1'b0;
                  busy_reg  <= 1'b0;
               end else begin
                  state <= S_DONE;
               end
            end
            default: begin
               state     <= S_IDLE;
               res_valid <= 1'b0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_sched.sv
// Directed and randomized bench for mult_sched with a round-robin / product model.
module tb_mult_sched;
   import mult_sched_pkg::*;

   localparam int W = TB_W;
   localparam int N = TB_N;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   m_ptr  = 0;

   always #5 clk = ~clk;

   mult_sched_if #(.W(W), .N(N)) bus ();

   mult_sched #(.W(W), .N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference arbiter: first pending requester at or after the model pointer.
   function automatic int model_grant(input logic [N-1:0] rv);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (rv[i]) return i;
      end
      return -1;
   endfunction

   task automatic scramble();
      for (int k = 0; k < N; k++) begin
         bus.req_a[k] = W'($urandom);
         bus.req_b[k] = W'($urandom);
      end
   endtask

   // One full operation: grant, latency, product, tag, optional result stall.
   task automatic run_op(input logic [N-1:0] rv, input bit keep, input int hold, input bit imm);
      int g;
      int n;
      logic [N-1:0] exp_rdy;
      logic [31:0]  exp_q;
      bus.req_v   = rv;
      bus.res_rdy = (hold == 0);
      g = model_grant(rv);
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      n = 0;
      @(negedge clk);
      while (bus.req_rdy == '0 && n < TB_TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      chk("grant", 32'(bus.req_rdy), 32'(exp_rdy));
      if (imm) chk("grant_wait", 32'(n), 32'd0);
      chk("idle_busy_at_grant", 32'(bus.busy), 32'd0);
      if (g < 0) g = 0;
      exp_q = 32'(bus.req_a[g]) * 32'(bus.req_b[g]);
      m_ptr = (g + 1) % N;
      @(posedge clk); #1;
      if (!keep) bus.req_v[g] = 1'b0;
      scramble();
      n = 0;
      do begin
         @(negedge clk);
         n++;
         chk("rdy_busy", 32'(bus.req_rdy), 32'd0);
         chk("busy_calc", 32'(bus.busy), 32'd1);
      end while (!bus.res_v && n < TB_TIMEOUT);
      chk("latency", 32'(n), 32'(TB_LAT));
      chk("res_q", 32'(bus.res_q), exp_q);
      chk("res_id", 32'(bus.res_id), 32'(g));
      repeat (hold) begin
         @(negedge clk);
         chk("hold_v", 32'(bus.res_v), 32'd1);
         chk("hold_q", 32'(bus.res_q), exp_q);
         chk("hold_id", 32'(bus.res_id), 32'(g));
         chk("hold_rdy", 32'(bus.req_rdy), 32'd0);
         chk("hold_busy", 32'(bus.busy), 32'd1);
      end
      if (hold > 0) begin
         @(posedge clk); #1;
         bus.res_rdy = 1'b1;
      end
      @(posedge clk); #1;
      if (hold > 0) bus.res_rdy = 1'b0;
      chk("after_done_v", 32'(bus.res_v), 32'd0);
      chk("after_done_busy", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int g;
      int n;
      logic [N-1:0] exp_rdy;
      rst         = 1'b0;
      bus.req_v   = '0;
      bus.res_rdy = 1'b1;
      for (int k = 0; k < N; k++) begin
         bus.req_a[k] = W'(10 * (k + 1));
         bus.req_b[k] = W'(7 + 3 * k);
      end

      // Reset values, including ready held low while requests are pending.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_res_v", 32'(bus.res_v), 32'd0);
      chk("rst_res_q", 32'(bus.res_q), 32'd0);
      chk("rst_res_id", 32'(bus.res_id), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      bus.req_v = '1;
      #1;
      chk("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // All requesters held high: grants rotate 0,1,2,3,0.
      for (int i = 0; i < 5; i++) begin
         run_op('1, 1'b1, 0, 1'b0);
      end

      // Directed operands from the plan.
      bus.req_a[0] = 8'd13;  bus.req_b[0] = 8'd11;
      run_op(4'b0001, 1'b0, 0, 1'b0);
      bus.req_a[1] = 8'd255; bus.req_b[1] = 8'd255;
      run_op(4'b0010, 1'b0, 0, 1'b0);
      bus.req_a[3] = 8'd0;   bus.req_b[3] = 8'd200;
      run_op(4'b1000, 1'b0, 0, 1'b0);

      // Result stalled 5 cycles, then the other pending request goes next.
      scramble();
      run_op(4'b1010, 1'b0, 5, 1'b0);
      run_op(bus.req_v, 1'b0, 0, 1'b1);

      // Reset four cycles into CALC with requester 2 active.
      bus.req_v   = 4'b0100;
      bus.res_rdy = 1'b1;
      g = model_grant(4'b0100);
      exp_rdy = '0;
      exp_rdy[g] = 1'b1;
      n = 0;
      @(negedge clk);
      while (bus.req_rdy == '0 && n < TB_TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      chk("abort_grant", 32'(bus.req_rdy), 32'(exp_rdy));
      @(posedge clk); #1;
      bus.req_v = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_res_v", 32'(bus.res_v), 32'd0);
      chk("abort_res_q", 32'(bus.res_q), 32'd0);
      chk("abort_res_id", 32'(bus.res_id), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_req_rdy", 32'(bus.req_rdy), 32'd0);
      rst   = 1'b1;
      m_ptr = 0;
      repeat (12) begin
         @(negedge clk);
         chk("abort_no_res", 32'(bus.res_v), 32'd0);
      end
      @(posedge clk); #1;
      run_op(4'b0101, 1'b0, 0, 1'b0);
      run_op(bus.req_v, 1'b0, 0, 1'b1);

      // Randomized requests and operands.
      for (int i = 0; i < 8; i++) begin
         scramble();
         run_op(N'($urandom_range(1, (1 << N) - 1)), 1'b0, 0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
